async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of storage entries; must be a power of two, minimum 4.
REQ-003 Parameter PTR_WIDTH, default $clog2(DEPTH): memory address width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port order SHALL be: clk, reset, wdata, rdata, wr_en, rd_en, full, empty, wr_error, rd_error.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 wdata  input  WIDTH  write data, sampled with wr_en.
REQ-009 rdata  output  WIDTH  registered read data.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request.
REQ-012 full  output  1  FIFO cannot accept a write.
REQ-013 empty  output  1  FIFO has no readable word.
REQ-014 wr_error  output  1  registered flag: write attempted while full.
REQ-015 rd_error  output  1  registered flag: read attempted while empty.

Function
REQ-016 Storage: DEPTH x WIDTH array. Storage is not reset.
REQ-017 Pointers: wptr and rptr are PTR_WIDTH+1-bit binary pointers. The MSB is the wrap bit. Each pointer is also held as a registered Gray-code copy (wptr_g, rptr_g).
REQ-018 Accepted write: wr_en=1 and full=0 at the clock edge.
  - Store mem[wptr[PTR_WIDTH-1:0]] <= wdata.
  - Increment wptr by 1, modulo 2^(PTR_WIDTH+1).
REQ-019 Accepted read: rd_en=1 and empty=0 at the clock edge.
  - Load rdata <= mem[rptr[PTR_WIDTH-1:0]].
  - Increment rptr by 1, modulo 2^(PTR_WIDTH+1).
  - rdata holds its value when no read is accepted.
REQ-020 Pointer crossing: rptr_g passes through a 2-flop synchronizer (wq2_rptr); wptr_g passes through a 2-flop synchronizer (rq2_wptr). Both synchronizers run on clk, keeping the structure portable to split clocks.
REQ-021 full SHALL be combinational from registers: full = (wptr_g == {~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1], wq2_rptr[PTR_WIDTH-2:0]}).
REQ-022 empty SHALL be combinational from registers: empty = (rptr_g == rq2_wptr).
REQ-023 Flag latency:
  - full asserts immediately after the edge that accepts the DEPTH-th outstanding write.
  - empty asserts immediately after the edge that accepts the read of the last word.
  - empty deasserts 2 edges after the first write into an empty FIFO.
  - full deasserts 2 edges after a read from a full FIFO.
  - These are pessimistic flags; they never permit overflow or underflow.
REQ-024 A write while full SHALL be ignored: no pointer or memory change. wr_error=1 for the following cycle; otherwise wr_error=0.
REQ-025 A read while empty SHALL be ignored: no pointer change, rdata held. rd_error=1 for the following cycle; otherwise rd_error=0.
REQ-026 Simultaneous wr_en and rd_en SHALL be evaluated independently against the current full/empty; both may be accepted on the same edge.
REQ-027 Data SHALL be returned in strict write order across pointer wrap-around.

Reset
REQ-028 While reset=1, with no dependence on clk:
  - wptr, rptr, Gray copies and all synchronizer flops = 0.
  - rdata = 0, wr_error = 0, rd_error = 0.
  - Hence empty=1 and full=0.
REQ-029 Reset asserted mid-operation SHALL discard all contents; the FIFO is empty on release.
REQ-030 Requests are honored from the first rising edge after reset deasserts.

Verification
REQ-031 Reset then idle -> empty=1, full=0, rdata=0, wr_error=0, rd_error=0.
REQ-032 16 consecutive writes (values 0x01..0x10, DEPTH=16) -> full=1 after the 16th edge. A 17th write (0xFF) -> wr_error=1 for one cycle; contents unchanged.
REQ-033 16 consecutive reads -> rdata = 0x01..0x10 in order, one per accepted edge. empty=1 after the 16th read. A further read -> rd_error=1 for one cycle; rdata stays 0x10.
REQ-034 One write of 0xA5 into an empty FIFO -> empty falls 2 edges later. A read then returns 0xA5, and empty rises after that edge.
REQ-035 Fill to 8 entries, then hold wr_en=rd_en=1 for 40 cycles with incrementing data -> no errors, order preserved across wrap, occupancy stays constant.
REQ-036 Fill to 10 entries, pulse reset for 1 ns asynchronously (between edges) -> empty=1, full=0, rdata=0 immediately. A subsequent write/read returns the newly written value.

Source files
------------

// File: rtl/async_fifo.sv
// async_fifo: Gray-pointer FIFO with 2-flop pointer synchronizers.
// Both sides run on one clock, but the write/read domains are kept separate
// so the block can later be split onto two clocks with no structural change.
module async_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic             wr_error,
  output logic             rd_error
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  // Binary to Gray: adjacent values differ in exactly one bit.
  function automatic logic [PTR_WIDTH:0] bin2gray(input logic [PTR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  // Storage (not reset)
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write-domain state
  logic [PTR_WIDTH:0] wptr_q, wptr_d;
  logic [PTR_WIDTH:0] wptr_g_q, wptr_g_d;
  logic [PTR_WIDTH:0] wq1_rptr_q, wq2_rptr_q;
  logic               wr_error_q, wr_error_d;

  // Read-domain state
  logic [PTR_WIDTH:0] rptr_q, rptr_d;
  logic [PTR_WIDTH:0] rptr_g_q, rptr_g_d;
  logic [PTR_WIDTH:0] rq1_wptr_q, rq2_wptr_q;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               rd_error_q, rd_error_d;

  logic wr_acc, rd_acc;

  // Flags are pure compares of registered pointers; they are pessimistic
  // because the opposite pointer is seen two edges late.
  assign full  = (wptr_g_q == {~wq2_rptr_q[PTR_WIDTH:PTR_WIDTH-1],
                               wq2_rptr_q[PTR_WIDTH-2:0]});
  assign empty = (rptr_g_q == rq2_wptr_q);

  // wr_en and rd_en are judged independently against the current flags.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Write-side next state: advance pointer on an accepted write, flag overflow.
  always_comb begin
    wptr_d     = wptr_q;
    wptr_g_d   = wptr_g_q;
    wr_error_d = wr_en & full;
    if (wr_acc) begin
      wptr_d   = wptr_q + PTR_ONE;
      wptr_g_d = bin2gray(wptr_q + PTR_ONE);
    end
  end

  // Read-side next state: advance pointer and load data on an accepted read.
  always_comb begin
    rptr_d     = rptr_q;
    rptr_g_d   = rptr_g_q;
    rdata_d    = rdata_q;
    rd_error_d = rd_en & empty;
    if (rd_acc) begin
      rptr_d   = rptr_q + PTR_ONE;
      rptr_g_d = bin2gray(rptr_q + PTR_ONE);
      rdata_d  = mem_q[rptr_q[PTR_WIDTH-1:0]];
    end
  end

  // Storage write; contents survive reset and are simply discarded by
  // the pointer reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[PTR_WIDTH-1:0]] <= wdata;
  end

  // Write pointer, its Gray copy and the overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      wptr_g_q   <= '0;
      wr_error_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      wptr_g_q   <= wptr_g_d;
      wr_error_q <= wr_error_d;
    end
  end

  // Read pointer, its Gray copy, read data and the underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q     <= '0;
      rptr_g_q   <= '0;
      rdata_q    <= '0;
      rd_error_q <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      rptr_g_q   <= rptr_g_d;
      rdata_q    <= rdata_d;
      rd_error_q <= rd_error_d;
    end
  end

  // Read Gray pointer into the write domain (2-flop synchronizer).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wq1_rptr_q <= '0;
      wq2_rptr_q <= '0;
    end else begin
      wq1_rptr_q <= rptr_g_q;
      wq2_rptr_q <= wq1_rptr_q;
    end
  end

  // Write Gray pointer into the read domain (2-flop synchronizer).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
    end else begin
      rq1_wptr_q <= wptr_g_q;
      rq2_wptr_q <= rq1_wptr_q;
    end
  end

  assign rdata    = rdata_q;
  assign wr_error = wr_error_q;
  assign rd_error = rd_error_q;

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed vectors with hand-computed expectations.
module tb_async_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wr_en, rd_en;
  logic       full, empty, wr_error, rd_error;

  int n_chk = 0;
  int n_err = 0;

  async_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wdata(wdata), .rdata(rdata),
    .wr_en(wr_en), .rd_en(rd_en), .full(full), .empty(empty),
    .wr_error(wr_error), .rd_error(rd_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
    #2;
    chk("rst_empty_async", empty, 1);
    chk("rst_full_async",  full,  0);
    #20;
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    chk("idle_empty", empty, 1);
    chk("idle_full",  full,  0);
    chk("idle_rdata", rdata, 0);
    chk("idle_wrerr", wr_error, 0);
    chk("idle_rderr", rd_error, 0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wdata = 8'(i);
      tick();
      if (i == 15) chk("full_at_15", full, 0);
    end
    chk("full_at_16", full, 1);
    wdata = 8'hFF;
    tick();
    chk("wrerr_set", wr_error, 1);
    chk("full_hold", full, 1);
    wr_en = 1'b0;
    tick();
    chk("wrerr_clr", wr_error, 0);
    chk("empty_when_full", empty, 0);

    // Drain 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_data", rdata, 32'(i));
      if (i == 15) chk("empty_at_15", empty, 0);
    end
    chk("empty_at_16", empty, 1);
    tick();
    chk("rderr_set", rd_error, 1);
    chk("rdata_hold", rdata, 32'h10);
    rd_en = 1'b0;
    tick();
    chk("rderr_clr", rd_error, 0);

    // Single word latency
    wr_en = 1'b1; wdata = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("a5_empty_e0", empty, 1);
    tick();
    chk("a5_empty_e1", empty, 1);
    tick();
    chk("a5_empty_e2", empty, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("a5_data",  rdata, 32'hA5);
    chk("a5_empty", empty, 1);

    // Fill 8, then 40 cycles of simultaneous read/write across wrap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wdata = 8'(32'h20 + i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wdata = 8'(32'h28 + k);
      tick();
      chk("stream_data", rdata, 32'h20 + k);
      chk("stream_errs", {wr_error, rd_error}, 0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      chk("tail_not_empty", empty, 0);
      rd_en = 1'b1;
      tick();
      chk("tail_data", rdata, 32'h48 + i);
    end
    rd_en = 1'b0;
    chk("tail_empty", empty, 1);

    // Fill 10, then asynchronous reset pulse between edges
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wdata = 8'(32'h60 + i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    chk("pre_rst_empty", empty, 0);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_full",  full,  0);
    chk("arst_rdata", rdata, 0);
    wr_en = 1'b1; wdata = 8'h77;
    tick();
    wr_en = 1'b0;
    tick(); tick();
    chk("post_rst_ne", empty, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_rst_data",  rdata, 32'h77);
    chk("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
